// File: rtl/ram_fifo_ctl.sv
// Pointer and flag controller that turns a two-port RAM (synchronous write port,
// combinational read port) into a show-ahead FIFO with sticky error flags.
module ram_fifo_ctl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DEPTH_LOG2-1:0] ram_in_addr,
  output logic                  ram_in_latch,
  output logic [DEPTH_LOG2-1:0] ram_out_addr,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          push_ok;
  logic          pop_ok;

  // Status is derived purely from the registered pointers; the extra wrap bit
  // distinguishes full from empty when the address bits coincide.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign ram_in_addr  = wr_ptr_q[DEPTH_LOG2-1:0];
  assign ram_out_addr = rd_ptr_q[DEPTH_LOG2-1:0];
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign push_ok      = push & ~full  & ~flush & ~reset;
  assign pop_ok       = pop  & ~empty & ~flush & ~reset;
  assign ram_in_latch = push_ok;

  // Next-state: flush wins over push/pop; rejected requests set sticky flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && full)  ovf_d = 1'b1;
      if (pop  && empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Occupancy can never exceed the RAM depth, and full/empty are exclusive.
  a_count_range: assert property (@(posedge clk) disable iff (reset)
    (count <= PW'(DEPTH)) && (DATA_WIDTH != 0));
  a_full_empty_excl: assert property (@(posedge clk) disable iff (reset)
    !(full && empty));

endmodule

// File: tb/tb_ram_fifo_ctl.sv
// Bench for ram_fifo_ctl: a behavioural RAM plus a queue-based FIFO model
// checked every cycle, and directed sequences with literal expectations.
module tb_ram_fifo_ctl;

  logic       clk = 1'b0;
  logic       reset, push, pop, flush;
  logic [7:0] din;
  logic [3:0] ram_in_addr, ram_out_addr;
  logic       ram_in_latch, empty, full, overflow, underflow;
  logic [4:0] count;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [7:0] tbram [16];
  logic [7:0] mq [$];
  bit         m_ovf = 1'b0, m_udf = 1'b0;
  int         sz;

  ram_fifo_ctl #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
    .ram_in_addr(ram_in_addr), .ram_in_latch(ram_in_latch),
    .ram_out_addr(ram_out_addr), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // RAM and FIFO reference model, advanced on each rising edge.
  always @(posedge clk) begin
    if (ram_in_latch) tbram[ram_in_addr] <= din;
    if (reset || flush) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      sz = mq.size();
      if (push && sz == 16) m_ovf = 1'b1;
      if (pop && sz == 0)   m_udf = 1'b1;
      if (pop && sz > 0)    void'(mq.pop_front());
      if (push && sz < 16)  mq.push_back(din);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_empty", 32'(empty), 32'(mq.size() == 0));
      chk("m_full", 32'(full), 32'(mq.size() == 16));
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_underflow", 32'(underflow), 32'(m_udf));
      chk("m_latch", 32'(ram_in_latch),
          32'(push && mq.size() < 16 && !flush && !reset));
      if (mq.size() > 0) chk("m_head", 32'(tbram[ram_out_addr]), 32'(mq[0]));
    end
  end

  task automatic set_in(input logic p, input logic q, input logic f, input logic r,
                        input logic [7:0] d);
    push = p; pop = q; flush = f; reset = r; din = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic p, input logic q, input logic f, input logic r,
                     input logic [7:0] d);
    set_in(p, q, f, r, d);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    chk_en = 1'b1;
    tick();
    // Reset held, push requested: nothing may be accepted.
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 8'h11);
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", 32'({overflow, underflow}), 32'd0);
    chk("rst_latch", 32'(ram_in_latch), 32'd0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Basic push/pop ordering.
    cyc(1, 0, 0, 0, 8'hA5);
    chk("s2_vis_after1", 32'(empty), 32'd0);
    chk("s2_head1", 32'(tbram[ram_out_addr]), 32'hA5);
    cyc(1, 0, 0, 0, 8'h3C);
    chk("s2_count2", 32'(count), 32'd2);
    chk("s2_headA5", 32'(tbram[ram_out_addr]), 32'hA5);
    cyc(0, 1, 0, 0, 8'h00);
    chk("s2_head3C", 32'(tbram[ram_out_addr]), 32'h3C);
    chk("s2_count1", 32'(count), 32'd1);
    cyc(0, 1, 0, 0, 8'h00);
    chk("s2_empty", 32'(empty), 32'd1);

    // Fill to full from address 0, overflow attempt, drain.
    cyc(0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 8'(i));
    chk("s3_full", 32'(full), 32'd1);
    chk("s3_count16", 32'(count), 32'd16);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'hEE);
    #1;
    chk("s3_latch_full", 32'(ram_in_latch), 32'd0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("s3_overflow", 32'(overflow), 32'd1);
    chk("s3_ram0", 32'(tbram[0]), 32'h00);
    for (int i = 0; i < 16; i++) begin
      chk("s3_drain", 32'(tbram[ram_out_addr]), 32'(i));
      cyc(0, 1, 0, 0, 8'h00);
    end
    chk("s3_empty", 32'(empty), 32'd1);
    chk("s3_ovf_sticky", 32'(overflow), 32'd1);
    cyc(0, 0, 1, 0, 8'h00);
    chk("s3_flush_clr", 32'(overflow), 32'd0);

    // Pointer wrap with simultaneous push+pop.
    for (int i = 0; i < 14; i++) begin
      cyc(1, 0, 0, 0, 8'(8'h20 + i));
      chk("s4_pair", 32'(tbram[ram_out_addr]), 32'(8'h20 + i));
      cyc(0, 1, 0, 0, 8'h00);
    end
    cyc(1, 0, 0, 0, 8'h50);
    for (int k = 0; k < 3; k++) begin
      chk("s4_head_pre", 32'(tbram[ram_out_addr]), 32'(8'h50 + k));
      cyc(1, 1, 0, 0, 8'(8'h51 + k));
      chk("s4_count", 32'(count), 32'd1);
      chk("s4_flags", 32'({full, empty}), 32'd0);
    end
    chk("s4_head_last", 32'(tbram[ram_out_addr]), 32'h53);
    cyc(0, 1, 0, 0, 8'h00);
    chk("s4_empty", 32'(empty), 32'd1);

    // Push+pop on empty, then on full.
    cyc(1, 1, 0, 0, 8'h77);
    chk("s5_underflow", 32'(underflow), 32'd1);
    chk("s5_count1", 32'(count), 32'd1);
    chk("s5_head77", 32'(tbram[ram_out_addr]), 32'h77);
    cyc(0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 8'(8'h80 + i));
    cyc(1, 1, 0, 0, 8'hFF);
    chk("s5_count15", 32'(count), 32'd15);
    chk("s5_overflow", 32'(overflow), 32'd1);
    chk("s5_head81", 32'(tbram[ram_out_addr]), 32'h81);

    // Flush at count=5 with a push in the same cycle.
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 8'h00);
    chk("s6_count5", 32'(count), 32'd5);
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 8'hCC);
    #1;
    chk("s6_flush_latch", 32'(ram_in_latch), 32'd0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("s6_flush_empty", 32'(empty), 32'd1);
    chk("s6_flush_count", 32'(count), 32'd0);
    chk("s6_flush_flags", 32'({overflow, underflow}), 32'd0);

    // Reset at count=9 with a push in the same cycle.
    cyc(0, 1, 0, 0, 8'h00);
    chk("s6_udf", 32'(underflow), 32'd1);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 8'(8'h90 + i));
    chk("s6_count9", 32'(count), 32'd9);
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 8'hDD);
    #1;
    chk("s6_rst_latch", 32'(ram_in_latch), 32'd0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("s6_rst_empty", 32'(empty), 32'd1);
    chk("s6_rst_count", 32'(count), 32'd0);
    chk("s6_rst_flags", 32'({overflow, underflow, full}), 32'd0);
    chk("s6_rst_addr", 32'({ram_in_addr, ram_out_addr}), 32'd0);
    cyc(1, 0, 0, 0, 8'h42);
    chk("s6_after_rst", 32'(tbram[ram_out_addr]), 32'h42);
    chk("s6_after_addr", 32'(ram_in_addr), 32'd1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
